ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clock-low inhibit length before start (100 us at 50 MHz).
REQ-002 SHALL have parameter SETUP_CYCLES, default 16: cycles data is held low, with clock still low, before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum gap between device clock falling edges (15 ms).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port tx_data, input, 8: command byte to the keyboard.
REQ-007 SHALL have port tx_valid, input, 1: request to transmit tx_data.
REQ-008 SHALL have port tx_ready, output, 1: high only in IDLE.
REQ-009 SHALL have port ps2c_in, input, 1: PS2C line sense, asynchronous.
REQ-010 SHALL have port ps2d_in, input, 1: PS2D line sense, asynchronous.
REQ-011 SHALL have port ps2c_oe, output, 1: 1 = pull PS2C low; 0 = release.
REQ-012 SHALL have port ps2d_oe, output, 1: 1 = pull PS2D low; 0 = release.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on acknowledged frame.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on timeout or missing ack.

Function
REQ-016 SHALL synchronise ps2c_in and ps2d_in through two flops each; a falling edge is previous synced clock 1 and current 0.
REQ-017 SHALL accept a byte when tx_valid and tx_ready are both high, latching frame {stop=1, parity=~^tx_data, tx_data} with LSB sent first.
REQ-018 SHALL use states IDLE -> INHIBIT -> START -> SHIFT -> ACK -> WAIT_IDLE -> IDLE.
REQ-019 INHIBIT SHALL last exactly INHIBIT_CYCLES cycles with ps2c_oe=1 and ps2d_oe=0.
REQ-020 START SHALL last exactly SETUP_CYCLES cycles with ps2c_oe=1 and ps2d_oe=1 (start bit).
REQ-021 SHALL release ps2c_oe on entry to SHIFT and keep it 0 in SHIFT, ACK and WAIT_IDLE.
REQ-022 In SHIFT, ps2d_oe SHALL stay 1 until falling edge 1; after falling edge n (n = 1..10), ps2d_oe SHALL be ~frame[n-1] from the next cycle.
REQ-023 Falling edges 1..8 SHALL present D0..D7, edge 9 the parity bit, and edge 10 the stop bit (ps2d_oe=0); after edge 10 the block SHALL enter ACK.
REQ-024 The 4-bit edge counter SHALL reset to 0 on accept and never wrap past 10.
REQ-025 In ACK, on the next falling edge the block SHALL sample synced PS2D: 0 -> WAIT_IDLE; 1 -> err pulse and IDLE.
REQ-026 WAIT_IDLE SHALL exit when synced PS2C and PS2D are both 1; done SHALL pulse in the first IDLE cycle.
REQ-027 tx_valid in the same cycle as a done or err pulse SHALL be accepted, since tx_ready is 1 in that cycle.
REQ-028 The watchdog counter SHALL clear on entry to SHIFT and on every falling edge, and count in SHIFT, ACK and WAIT_IDLE.
REQ-029 On reaching TIMEOUT_CYCLES the watchdog SHALL release both outputs, pulse err, and return to IDLE.
REQ-030 done and err SHALL never be asserted in the same cycle.
REQ-031 tx_data and tx_valid SHALL be ignored while busy; the latched frame SHALL not change mid-frame.

Reset
REQ-032 With rst=0 at a clock edge, the block SHALL enter IDLE.
REQ-033 On reset, ps2c_oe, ps2d_oe, busy, done and err SHALL be 0 and tx_ready SHALL be 1.
REQ-034 On reset, all counters and synchroniser flops SHALL be cleared, with synchroniser flops set to 1 (idle line level).
REQ-035 Reset mid-frame SHALL release both lines on the next edge, with no err or done pulse.

Verification
REQ-036 Send 0xED with a device model that acks -> PS2D bits after edges 1..10 = 1,0,1,1,0,1,1,1,1,1; ack low; done pulse once; err stays 0.
REQ-037 Send 0xF4 -> ps2c_oe high exactly 5000+16 cycles; ps2d_oe rises exactly 5000 cycles after accept; parity bit = 0.
REQ-038 Device never clocks -> err pulses 750000 cycles after SHIFT entry; both oe = 0; tx_ready = 1.
REQ-039 Device leaves PS2D high at edge 11 for 0x00 (parity 1) -> err pulse; done stays 0.
REQ-040 Reset (rst=0) after edge 5 -> next cycle ps2c_oe=0, ps2d_oe=0, tx_ready=1; a new 0xFF (parity 1) then completes with done.
REQ-041 tx_valid held high across a done pulse -> second frame accepted in the done cycle; busy is high from the following cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device command transmitter. Inhibits the bus,
//             issues a request-to-send, shifts a byte plus parity and stop
//             on device-generated clock edges, checks the device ack and
//             waits for the bus to return idle. Watchdog guards the
//             device-clocked phases.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state;
  logic [9:0]        frame;      // {stop, parity, data[7:0]}, bit 0 sent first
  logic [3:0]        bit_cnt;    // device falling edges seen in this frame
  logic [PH_W-1:0]   phase_cnt;  // times the host-driven INHIBIT / START phases
  logic [WD_W-1:0]   wd_cnt;     // cycles since the last device clock activity

  logic c_meta, c_sync, c_prev;
  logic d_meta, d_sync;
  logic c_fall;
  logic wd_expired;

  assign c_fall     = c_prev & ~c_sync;
  assign wd_expired = (wd_cnt == WD_LAST);
  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  // Two-flop synchronisers for the open-collector lines, plus a history
  // flop on the clock for falling-edge detection. Idle line level is 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      c_prev <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c_in;
      c_sync <= c_meta;
      c_prev <= c_sync;
      d_meta <= ps2d_in;
      d_sync <= d_meta;
    end
  end

  // Frame sequencer with registered line drivers and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      wd_cnt    <= '0;
      ps2c_oe   <= 1'b0;
      ps2d_oe   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            frame     <= {1'b1, ~^tx_data, tx_data};
            bit_cnt   <= '0;
            phase_cnt <= '0;
            ps2c_oe   <= 1'b1;
            ps2d_oe   <= 1'b0;
            state     <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (phase_cnt == INH_LAST) begin
            phase_cnt <= '0;
            ps2d_oe   <= 1'b1;          // start bit, clock still held low
            state     <= START;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        START: begin
          if (phase_cnt == SET_LAST) begin
            ps2c_oe <= 1'b0;            // hand the clock over to the device
            wd_cnt  <= '0;
            state   <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (c_fall) begin
            wd_cnt  <= '0;
            ps2d_oe <= ~frame[bit_cnt];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state <= ACK;
            end
          end else if (wd_expired) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        ACK: begin
          if (c_fall) begin
            wd_cnt <= '0;
            if (!d_sync) begin
              state <= WAIT_IDLE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (wd_expired) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (c_sync && d_sync) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (c_fall) begin
            wd_cnt <= '0;
          end else if (wd_expired) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Directed self-checking bench for ps2_host_tx with a simple
//             PS/2 device model and scoreboards for line bits and outcomes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int SET = 4;
  localparam int TO  = 300;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       busy, done, err;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;

  int total = 0;
  int bad   = 0;

  logic       bitq[$];   // expected line level after each device falling edge
  logic [1:0] outq[$];   // expected {done, err} per accepted frame

  // Open-collector bus: either side can pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  // Free-running system clock.
  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic [1:0] outcome);
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    bitq.push_back(~^b);
    bitq.push_back(1'b1);
    outq.push_back(outcome);
  endtask

  // Present a byte for one cycle; returns at the first negedge after accept.
  task automatic accept(input logic [7:0] b, input logic [1:0] outcome);
    @(negedge clk);
    chk("ready_before_accept", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    push_frame(b, outcome);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  // Counts clock-inhibit cycles from the current negedge; exits in SHIFT.
  task automatic measure_inhibit(input string tag);
    int nd = 0;
    int nb = 0;
    int g  = 0;
    while (ps2c_oe && g < INH + SET + 50) begin
      if (!ps2d_oe) nd++;
      else nb++;
      @(negedge clk);
      g++;
    end
    chk({tag, "_data_low_len"}, 32'(nd), INH);
    chk({tag, "_setup_len"}, 32'(nb), SET);
    chk({tag, "_clock_low_len"}, 32'(nd + nb), INH + SET);
    chk({tag, "_start_bit_held"}, 32'(ps2d_oe), 1);
  endtask

  // Device model: generates clock pulses, samples the line before each rise.
  task automatic dev_clock(input int npulse, input logic ack);
    logic e;
    for (int n = 1; n <= npulse; n++) begin
      repeat (6) @(negedge clk);
      if (n == 11) begin
        dev_dat = ~ack;
        repeat (2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (8) @(negedge clk);
      if (n <= 10) begin
        e = (bitq.size() != 0) ? bitq.pop_front() : 1'bx;
        chk("line_bit", 32'(ps2d_in), 32'(e));
      end
      dev_clk = 1'b1;
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_outcome(input string tag);
    int g = 0;
    while (outq.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk({tag, "_outcome_seen"}, 32'(outq.size()), 0);
    chk({tag, "_idle_ready"}, 32'(tx_ready), 1);
    chk({tag, "_idle_lines"}, 32'({ps2c_oe, ps2d_oe}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    int g;

    // Outcome monitor: every done/err pulse must match the next expected result.
    fork
      forever begin
        logic [1:0] e;
        @(negedge clk);
        if (rst && (done || err)) begin
          e = (outq.size() != 0) ? outq.pop_front() : 2'bxx;
          chk("outcome", 32'({done, err}), 32'(e));
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lines", 32'({ps2c_oe, ps2d_oe}), 0);
    chk("rst_pulses", 32'({done, err}), 0);
    rst = 1'b1;

    // 0xED acknowledged
    accept(8'hED, 2'b10);
    measure_inhibit("ed");
    dev_clock(11, 1'b1);
    wait_outcome("ed");

    // 0xF4 acknowledged, timing of inhibit/start phases
    accept(8'hF4, 2'b10);
    measure_inhibit("f4");
    dev_clock(11, 1'b1);
    wait_outcome("f4");

    // Device never clocks: watchdog timeout
    accept(8'h81, 2'b01);
    measure_inhibit("to");
    k = 0;
    while (!err && k < TO + 50) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_len", 32'(k), TO);
    chk("timeout_lines", 32'({ps2c_oe, ps2d_oe}), 0);
    chk("timeout_ready", 32'(tx_ready), 1);
    bitq.delete();
    wait_outcome("to");

    // 0x00 with device leaving PS2D high at the ack edge
    accept(8'h00, 2'b01);
    measure_inhibit("nack");
    dev_clock(11, 1'b0);
    wait_outcome("nack");

    // Reset mid-frame after edge 5
    accept(8'hA5, 2'b10);
    measure_inhibit("abort");
    dev_clock(5, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    bitq.delete();
    @(negedge clk);
    chk("abort_lines", 32'({ps2c_oe, ps2d_oe}), 0);
    chk("abort_ready", 32'(tx_ready), 1);
    chk("abort_pulses", 32'({done, err}), 0);
    rst = 1'b1;
    accept(8'hFF, 2'b10);
    measure_inhibit("ff");
    dev_clock(11, 1'b1);
    wait_outcome("ff");

    // tx_valid held across the done pulse: back-to-back frames
    accept(8'h5A, 2'b10);
    measure_inhibit("b2b1");
    dev_clock(11, 1'b1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    g = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("b2b_done", 32'(done), 1);
    chk("b2b_ready_in_done", 32'(tx_ready), 1);
    push_frame(8'h3C, 2'b10);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'hC3;
    chk("b2b_busy_next", 32'(busy), 1);
    chk("b2b_done_single", 32'(done), 0);
    measure_inhibit("b2b2");
    dev_clock(11, 1'b1);
    wait_outcome("b2b2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
